// File: rtl/rf_pkg.sv
// -----------------------------------------------------------------------------
// rf_pkg
// Shared definitions for the rf_sb register file with scoreboard:
//   - sweep/ready state encoding
//   - rf_aw(): address width derived from the register count
// No ports (package).
// -----------------------------------------------------------------------------
package rf_pkg;

   // Register-file controller states
   localparam logic [0:0] SWEEP = 1'b0;
   localparam logic [0:0] READY = 1'b1;

   // Address width for a register count; at least one bit even for tiny arrays
   function automatic int rf_aw(input int nregs);
      if (nregs > 2) begin
         return $clog2(nregs);
      end else begin
         return 1;
      end
   endfunction

endpackage

// File: rtl/rf_sb_if.sv
// -----------------------------------------------------------------------------
// rf_sb_if
// Bus bundle for rf_sb (everything except clock and reset).
//   i_clr                 synchronous re-initialise request
//   o_ready               array initialised, accepting traffic
//   i_raddr / o_rdata     packed read addresses / read data (NRD ports)
//   o_rbusy               per read port: register has a pending write
//   i_iss_valid/_addr     issue: mark destination pending
//   i_rd_wen/_waddr/_wdata writeback
//   o_pend_cnt            number of pending registers
// Modports: slave (the register file), master (the driver of traffic).
// -----------------------------------------------------------------------------
interface rf_sb_if
   import rf_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int NRD   = 2
);

   localparam int AW = rf_aw(NREGS);

   logic                  i_clr;
   logic                  o_ready;
   logic [NRD*AW-1:0]     i_raddr;
   logic [NRD*XLEN-1:0]   o_rdata;
   logic [NRD-1:0]        o_rbusy;
   logic                  i_iss_valid;
   logic [AW-1:0]         i_iss_addr;
   logic                  i_rd_wen;
   logic [AW-1:0]         i_rd_waddr;
   logic [XLEN-1:0]       i_rd_wdata;
   logic [AW:0]           o_pend_cnt;

   modport slave (
      input  i_clr, i_raddr, i_iss_valid, i_iss_addr, i_rd_wen, i_rd_waddr, i_rd_wdata,
      output o_ready, o_rdata, o_rbusy, o_pend_cnt
   );

   modport master (
      output i_clr, i_raddr, i_iss_valid, i_iss_addr, i_rd_wen, i_rd_waddr, i_rd_wdata,
      input  o_ready, o_rdata, o_rbusy, o_pend_cnt
   );

endinterface

// File: rtl/rf_scoreboard.sv
// -----------------------------------------------------------------------------
// rf_scoreboard
// Busy (pending-write) bits for every register plus a running count of them.
// Strobes arrive already qualified (ready, zero-register filtering done by the
// caller).
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_clr                 clear all busy bits and the count
//   i_set, i_set_addr     issue: set busy
//   i_rel, i_rel_addr     writeback: clear busy
//   o_busy                busy vector
//   o_pend_cnt            population of o_busy
// -----------------------------------------------------------------------------
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int NREGS = 32,
   parameter int AW    = rf_aw(NREGS)
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_clr,
   input  logic              i_set,
   input  logic [AW-1:0]     i_set_addr,
   input  logic              i_rel,
   input  logic [AW-1:0]     i_rel_addr,
   output logic [NREGS-1:0]  o_busy,
   output logic [AW:0]       o_pend_cnt
);

   localparam logic [AW:0] CNT_ONE = (AW+1)'(1'b1);

   logic [NREGS-1:0] busy_q, busy_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             inc_s, dec_s;

   // Next busy vector and count; a same-cycle issue overrides the writeback
   always_comb begin
      busy_d = busy_q;
      cnt_d  = cnt_q;
      inc_s  = 1'b0;
      dec_s  = 1'b0;
      if (i_clr) begin
         busy_d = {NREGS{1'b0}};
         cnt_d  = {(AW+1){1'b0}};
      end else begin
         // count only real 0->1 and 1->0 transitions so it tracks the population
         inc_s = i_set & ~busy_q[i_set_addr];
         dec_s = i_rel & busy_q[i_rel_addr] & ~(i_set & (i_set_addr == i_rel_addr));
         if (i_rel) begin
            busy_d[i_rel_addr] = 1'b0;
         end else begin
            busy_d = busy_d;
         end
         if (i_set) begin
            busy_d[i_set_addr] = 1'b1;
         end else begin
            busy_d = busy_d;
         end
         case ({inc_s, dec_s})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   // Busy and count registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         busy_q <= {NREGS{1'b0}};
         cnt_q  <= {(AW+1){1'b0}};
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   assign o_busy     = busy_q;
   assign o_pend_cnt = cnt_q;

endmodule

// File: rtl/rf_sb.sv
// -----------------------------------------------------------------------------
// rf_sb
// Multi-port register file with pending-write scoreboard. After reset or a
// clear request the array is swept to zero one register per cycle; traffic is
// accepted only once the sweep has finished (o_ready).
//   i_clk     global clock
//   i_rst_n   asynchronous active-low reset
//   bus       rf_sb_if.slave: clear, reads, issue, writeback, status
// Reads are combinational; optional write-to-read forwarding; optional
// hardwired-zero register 0.
// -----------------------------------------------------------------------------
module rf_sb
   import rf_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int NREGS     = 32,
   parameter int NRD       = 2,
   parameter int BYPASS_EN = 1,
   parameter int ZERO_REG  = 1
) (
   input  logic   i_clk,
   input  logic   i_rst_n,
   rf_sb_if.slave bus
);

   localparam int            AW        = rf_aw(NREGS);
   localparam logic [AW-1:0] LAST_IDX  = AW'(NREGS-1);
   localparam logic [AW-1:0] IDX_ONE   = AW'(1'b1);
   localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};
   localparam logic [XLEN-1:0] DATA_ZERO = {XLEN{1'b0}};

   logic [0:0]      state_q, state_d;
   logic [AW-1:0]   idx_q, idx_d;
   logic            ready_s;
   logic            clr_s;
   logic            wb_eff_s;
   logic            iss_eff_s;
   logic [NREGS-1:0] busy_s;
   logic [AW:0]     pend_cnt_s;
   logic [XLEN-1:0] regs_q [NREGS];
   logic [XLEN-1:0] regs_d [NREGS];
   logic [NRD*XLEN-1:0] rdata_s;
   logic [NRD-1:0]  rbusy_s;

   assign ready_s = (state_q == READY);

   // Qualify requests: only honoured when ready, and never for a hardwired x0
   always_comb begin
      clr_s     = ready_s & bus.i_clr;
      wb_eff_s  = ready_s & bus.i_rd_wen;
      iss_eff_s = ready_s & bus.i_iss_valid;
      if ((ZERO_REG != 0) && (bus.i_rd_waddr == ADDR_ZERO)) begin
         wb_eff_s = 1'b0;
      end else begin
         wb_eff_s = wb_eff_s;
      end
      if ((ZERO_REG != 0) && (bus.i_iss_addr == ADDR_ZERO)) begin
         iss_eff_s = 1'b0;
      end else begin
         iss_eff_s = iss_eff_s;
      end
   end

   // Sweep/ready controller; clear is only honoured in READY
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         SWEEP: begin
            if (idx_q == LAST_IDX) begin
               state_d = READY;
               idx_d   = ADDR_ZERO;
            end else begin
               idx_d = idx_q + IDX_ONE;
            end
         end
         READY: begin
            if (bus.i_clr) begin
               state_d = SWEEP;
               idx_d   = ADDR_ZERO;
            end else begin
               state_d = READY;
            end
         end
         default: begin
            state_d = SWEEP;
            idx_d   = ADDR_ZERO;
         end
      endcase
   end

   // Controller registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= SWEEP;
         idx_q   <= ADDR_ZERO;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Array update: sweep zeroing has the write port while not ready
   always_comb begin
      regs_d = regs_q;
      if (!ready_s) begin
         regs_d[idx_q] = DATA_ZERO;
      end else if (wb_eff_s) begin
         regs_d[bus.i_rd_waddr] = bus.i_rd_wdata;
      end else begin
         regs_d = regs_q;
      end
   end

   // Array storage is initialised by the sweep, not by reset
   always_ff @(posedge i_clk) begin
      regs_q <= regs_d;
   end

   rf_scoreboard #(
      .NREGS (NREGS),
      .AW    (AW)
   ) u_scoreboard (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_clr      (clr_s),
      .i_set      (iss_eff_s),
      .i_set_addr (bus.i_iss_addr),
      .i_rel      (wb_eff_s),
      .i_rel_addr (bus.i_rd_waddr),
      .o_busy     (busy_s),
      .o_pend_cnt (pend_cnt_s)
   );

   // Read ports: zero while sweeping, x0 forced, optional writeback forwarding
   always_comb begin
      logic [AW-1:0] ra;
      ra      = ADDR_ZERO;
      rdata_s = {(NRD*XLEN){1'b0}};
      rbusy_s = {NRD{1'b0}};
      for (int k = 0; k < NRD; k++) begin
         ra = bus.i_raddr[k*AW +: AW];
         if (!ready_s) begin
            rdata_s[k*XLEN +: XLEN] = DATA_ZERO;
            rbusy_s[k]              = 1'b0;
         end else if ((ZERO_REG != 0) && (ra == ADDR_ZERO)) begin
            rdata_s[k*XLEN +: XLEN] = DATA_ZERO;
            rbusy_s[k]              = 1'b0;
         end else if ((BYPASS_EN != 0) && wb_eff_s && (bus.i_rd_waddr == ra)) begin
            // forwarded data is final unless a same-cycle issue re-marks it
            rdata_s[k*XLEN +: XLEN] = bus.i_rd_wdata;
            rbusy_s[k]              = iss_eff_s & (bus.i_iss_addr == ra);
         end else begin
            rdata_s[k*XLEN +: XLEN] = regs_q[ra];
            rbusy_s[k]              = busy_s[ra];
         end
      end
   end

   assign bus.o_ready    = ready_s;
   assign bus.o_rdata    = rdata_s;
   assign bus.o_rbusy    = rbusy_s;
   assign bus.o_pend_cnt = pend_cnt_s;

endmodule

// File: tb/tb_rf_sb.sv
// -----------------------------------------------------------------------------
// tb_rf_sb
// Two rf_sb instances (forwarding on / off) driven with identical directed
// traffic. Stimulus queues expected values tagged with the cycle they apply
// to; a monitor on the falling edge pops and compares them.
// -----------------------------------------------------------------------------
module tb_rf_sb;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int NRD   = 2;
   localparam int AW    = 5;

   localparam int F_RDY  = 0;
   localparam int F_RD0  = 1;
   localparam int F_RD1  = 2;
   localparam int F_BSY0 = 3;
   localparam int F_BSY1 = 4;
   localparam int F_PEND = 5;

   typedef struct {
      int          cyc;
      int          dut;
      int          fld;
      logic [31:0] val;
      string       name;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc    = 0;
   int   n_chk  = 0;
   int   n_fail = 0;
   exp_t exp_q[$];
   exp_t cur;
   logic [31:0] got;

   rf_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus_b ();
   rf_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus_n ();

   rf_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS_EN(1), .ZERO_REG(1)) dut_b (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus_b)
   );

   rf_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS_EN(0), .ZERO_REG(1)) dut_n (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] act(input int d, input int f);
      logic [31:0] r;
      r = 32'h0;
      case (f)
         F_RDY:  r = (d == 0) ? 32'(bus_b.o_ready)      : 32'(bus_n.o_ready);
         F_RD0:  r = (d == 0) ? bus_b.o_rdata[31:0]     : bus_n.o_rdata[31:0];
         F_RD1:  r = (d == 0) ? bus_b.o_rdata[63:32]    : bus_n.o_rdata[63:32];
         F_BSY0: r = (d == 0) ? 32'(bus_b.o_rbusy[0])   : 32'(bus_n.o_rbusy[0]);
         F_BSY1: r = (d == 0) ? 32'(bus_b.o_rbusy[1])   : 32'(bus_n.o_rbusy[1]);
         F_PEND: r = (d == 0) ? 32'(bus_b.o_pend_cnt)   : 32'(bus_n.o_pend_cnt);
         default: r = 32'hFFFF_FFFF;
      endcase
      return r;
   endfunction

   // Monitor: compare every expectation due in the current cycle
   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         cur = exp_q.pop_front();
         got = act(cur.dut, cur.fld);
         n_chk++;
         if (cur.cyc != cyc || got !== cur.val) begin
            n_fail++;
            $display("FAIL %s dut=%s cyc=%0d got=%h expected=%h",
                     cur.name, (cur.dut == 0) ? "bypass" : "nobypass", cyc, got, cur.val);
         end
      end
   end

   task automatic push(input int d, input int f, input logic [31:0] v, input string nm);
      exp_t e;
      e.cyc  = cyc;
      e.dut  = d;
      e.fld  = f;
      e.val  = v;
      e.name = nm;
      exp_q.push_back(e);
   endtask

   task automatic exp_both(input int f, input logic [31:0] v, input string nm);
      push(0, f, v, nm);
      push(1, f, v, nm);
   endtask

   task automatic drive(input int clr, input int r0, input int r1, input int iv, input int ia,
                        input int we, input int wa, input logic [31:0] wd);
      bus_b.i_clr       = clr[0];
      bus_b.i_raddr     = {AW'(r1), AW'(r0)};
      bus_b.i_iss_valid = iv[0];
      bus_b.i_iss_addr  = AW'(ia);
      bus_b.i_rd_wen    = we[0];
      bus_b.i_rd_waddr  = AW'(wa);
      bus_b.i_rd_wdata  = wd;
      bus_n.i_clr       = clr[0];
      bus_n.i_raddr     = {AW'(r1), AW'(r0)};
      bus_n.i_iss_valid = iv[0];
      bus_n.i_iss_addr  = AW'(ia);
      bus_n.i_rd_wen    = we[0];
      bus_n.i_rd_waddr  = AW'(wa);
      bus_n.i_rd_wdata  = wd;
   endtask

   task automatic rd(input int r0, input int r1);
      drive(0, r0, r1, 0, 0, 0, 0, 32'h0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sweep_wait(input string nm);
      for (int i = 0; i < NREGS; i++) begin
         exp_both(F_RDY, 32'h0, nm);
         step();
      end
      exp_both(F_RDY, 32'h1, {nm, "_done"});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      rd(0, 0);
      step();
      step();
      exp_both(F_RDY, 32'h0, "rst_ready");
      exp_both(F_PEND, 32'h0, "rst_pend");
      exp_both(F_RD0, 32'h0, "rst_rdata");
      step();

      // Reset release and initial sweep
      rst_n = 1'b1;
      sweep_wait("init_sweep");
      for (int r = 0; r < NREGS; r++) begin
         rd(r, NREGS - 1 - r);
         exp_both(F_RD0, 32'h0, "init_rd0");
         exp_both(F_RD1, 32'h0, "init_rd1");
         exp_both(F_BSY0, 32'h0, "init_bsy");
         step();
      end

      // Plain write/read and hardwired x0
      drive(0, 0, 0, 0, 0, 1, 5, 32'hDEAD_BEEF);
      step();
      rd(5, 0);
      exp_both(F_RD0, 32'hDEAD_BEEF, "x5_read");
      exp_both(F_RD1, 32'h0, "x0_read");
      step();
      drive(0, 0, 0, 0, 0, 1, 0, 32'h1);
      exp_both(F_RD0, 32'h0, "x0_fwd");
      step();
      rd(0, 5);
      exp_both(F_RD0, 32'h0, "x0_after_wr");
      exp_both(F_RD1, 32'hDEAD_BEEF, "x5_port1");
      step();

      // Forwarding on/off
      drive(0, 7, 7, 0, 0, 1, 7, 32'h1234);
      push(0, F_RD0, 32'h1234, "fwd_data");
      push(0, F_BSY0, 32'h0, "fwd_busy");
      push(1, F_RD0, 32'h0, "nofwd_old");
      push(1, F_BSY0, 32'h0, "nofwd_busy");
      step();
      rd(7, 7);
      exp_both(F_RD0, 32'h1234, "x7_stored");
      step();
      drive(0, 7, 0, 1, 7, 1, 7, 32'h5678);
      push(0, F_RD0, 32'h5678, "fwd_iss_data");
      push(0, F_BSY0, 32'h1, "fwd_iss_busy");
      push(1, F_RD0, 32'h1234, "nofwd_iss_data");
      push(1, F_BSY0, 32'h0, "nofwd_iss_busy");
      step();
      rd(7, 7);
      exp_both(F_RD0, 32'h5678, "x7_iss_wb");
      exp_both(F_BSY0, 32'h1, "x7_busy");
      exp_both(F_PEND, 32'h1, "x7_pend");
      step();
      drive(0, 7, 7, 0, 0, 1, 7, 32'h9);
      push(0, F_RD0, 32'h9, "fwd_rel_data");
      push(0, F_BSY0, 32'h0, "fwd_rel_busy");
      push(1, F_RD0, 32'h5678, "nofwd_rel_data");
      push(1, F_BSY0, 32'h1, "nofwd_rel_busy");
      step();
      rd(7, 7);
      exp_both(F_RD0, 32'h9, "x7_rel");
      exp_both(F_BSY0, 32'h0, "x7_rel_busy");
      exp_both(F_PEND, 32'h0, "x7_rel_pend");
      step();

      // Pending count sequence
      drive(0, 3, 4, 1, 3, 0, 0, 32'h0);
      exp_both(F_PEND, 32'h0, "cnt_start");
      step();
      drive(0, 3, 4, 1, 4, 0, 0, 32'h0);
      exp_both(F_PEND, 32'h1, "cnt_iss_x3");
      exp_both(F_BSY0, 32'h1, "x3_busy");
      step();
      drive(0, 3, 4, 0, 0, 1, 3, 32'h33);
      exp_both(F_PEND, 32'h2, "cnt_iss_x4");
      exp_both(F_BSY1, 32'h1, "x4_busy_a");
      push(0, F_RD0, 32'h33, "x3_fwd");
      push(0, F_BSY0, 32'h0, "x3_fwd_busy");
      push(1, F_RD0, 32'h0, "x3_nofwd");
      push(1, F_BSY0, 32'h1, "x3_nofwd_busy");
      step();
      drive(0, 4, 3, 1, 4, 1, 4, 32'h44);
      exp_both(F_PEND, 32'h1, "cnt_wb_x3");
      push(0, F_RD0, 32'h44, "x4_fwd");
      push(0, F_BSY0, 32'h1, "x4_fwd_busy");
      push(1, F_RD0, 32'h0, "x4_nofwd");
      push(1, F_BSY0, 32'h1, "x4_nofwd_busy");
      exp_both(F_RD1, 32'h33, "x3_stored");
      exp_both(F_BSY1, 32'h0, "x3_clear");
      step();
      rd(4, 3);
      exp_both(F_PEND, 32'h1, "cnt_iss_wb_x4");
      exp_both(F_BSY0, 32'h1, "x4_busy_b");
      exp_both(F_RD0, 32'h44, "x4_stored");
      step();
      drive(0, 9, 0, 0, 0, 1, 9, 32'h99);
      step();
      drive(0, 0, 9, 1, 0, 0, 0, 32'h0);
      exp_both(F_PEND, 32'h1, "cnt_wb_nonbusy");
      exp_both(F_RD1, 32'h99, "x9_stored");
      step();
      rd(0, 4);
      exp_both(F_PEND, 32'h1, "cnt_iss_x0");
      exp_both(F_BSY0, 32'h0, "x0_never_busy");
      exp_both(F_BSY1, 32'h1, "x4_busy_c");
      step();

      // Clear request: sweep again, ignored traffic and clear during sweep
      drive(1, 5, 4, 0, 0, 0, 0, 32'h0);
      exp_both(F_RDY, 32'h1, "pre_clr_ready");
      step();
      for (int i = 0; i < NREGS; i++) begin
         if (i == 20) begin
            drive(1, 5, 4, 1, 6, 1, 5, 32'hAAAA);
         end else begin
            rd(5, 4);
         end
         exp_both(F_RDY, 32'h0, "clr_ready_low");
         exp_both(F_RD0, 32'h0, "clr_rd_zero");
         exp_both(F_BSY1, 32'h0, "clr_bsy_zero");
         exp_both(F_PEND, 32'h0, "clr_pend_zero");
         step();
      end
      rd(0, 0);
      exp_both(F_RDY, 32'h1, "clr_sweep_done");
      exp_both(F_PEND, 32'h0, "clr_pend_after");
      for (int r = 0; r < NREGS; r++) begin
         rd(r, NREGS - 1 - r);
         exp_both(F_RD0, 32'h0, "clr_rd0");
         exp_both(F_RD1, 32'h0, "clr_rd1");
         exp_both(F_BSY0, 32'h0, "clr_bsy");
         step();
      end

      // Reset mid-traffic, then mid-sweep at idx 10
      drive(0, 8, 0, 1, 8, 0, 0, 32'h0);
      step();
      rd(8, 0);
      exp_both(F_PEND, 32'h1, "x8_pend");
      exp_both(F_BSY0, 32'h1, "x8_busy");
      step();
      rst_n = 1'b0;
      exp_both(F_RDY, 32'h0, "rst_traffic_ready");
      exp_both(F_PEND, 32'h0, "rst_traffic_pend");
      exp_both(F_BSY0, 32'h0, "rst_traffic_busy");
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         exp_both(F_RDY, 32'h0, "pre_mid_rst");
         step();
      end
      rst_n = 1'b0;
      exp_both(F_RDY, 32'h0, "rst_mid_sweep");
      step();
      step();
      rst_n = 1'b1;
      sweep_wait("restart_sweep");
      exp_both(F_PEND, 32'h0, "restart_pend");
      step();
      step();

      n_chk++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/rf_sb.md
RF_SB -- requirements
Module: rf_sb

Interface
REQ-001 Parameters (name, default, meaning), one per line, SHALL be:
 XLEN 32 data width
 NREGS 32 register count, power of two, >=2
 NRD 2 read port count, 1..4
 BYPASS_EN 1 write-to-read forwarding enable
 ZERO_REG 1 register 0 hardwired to zero when 1
REQ-002 Ports (name, direction, width, meaning), clock and reset first, SHALL be:
 i_clk input 1 global clock
 i_rst_n input 1 asynchronous active-low reset
 i_clr input 1 synchronous re-initialise request
 o_ready output 1 array initialised, accepting traffic
 i_raddr input NRD*AW packed read addresses, port k at [k*AW +: AW], AW=$clog2(NREGS)
 o_rdata output NRD*XLEN packed read data
 o_rbusy output NRD read register has a pending write
 i_iss_valid input 1 issue: mark i_iss_addr pending
 i_iss_addr input AW issue destination
 i_rd_wen input 1 writeback enable
 i_rd_waddr input AW writeback address
 i_rd_wdata input XLEN writeback data
 o_pend_cnt output AW+1 number of pending registers

Function
REQ-003 FSM SHALL have states SWEEP and READY; o_ready = (state==READY).
REQ-004 In SWEEP, index idx SHALL count 0..NREGS-1, writing 0 to reg[idx] each cycle; at idx==NREGS-1 the next state SHALL be READY (exactly NREGS cycles).
REQ-005 In READY, i_clr=1 SHALL move to SWEEP with idx=0 and clear all busy bits in the same edge.
REQ-006 While not ready, writebacks and issues SHALL be ignored, o_rdata and o_rbusy SHALL read 0.
REQ-007 Reads SHALL be combinational; each port independent; same address on multiple ports allowed.
REQ-008 When ZERO_REG=1, address 0 SHALL read 0, never go busy, and writes/issues to it SHALL be discarded.
REQ-009 Writeback with i_rd_wen=1 in READY SHALL update reg[i_rd_waddr] at the next edge and clear its busy bit.
REQ-010 Issue with i_iss_valid=1 in READY SHALL set busy[i_iss_addr] at the next edge.
REQ-011 Issue and writeback to the same address in one cycle: data SHALL be written, busy SHALL end set (issue wins).
REQ-012 BYPASS_EN=1: a read matching a same-cycle valid writeback SHALL return i_rd_wdata and o_rbusy=0, unless a same-cycle issue targets that address (then o_rbusy=1).
REQ-013 BYPASS_EN=0: reads SHALL return stored contents and stored busy only.
REQ-014 o_pend_cnt SHALL equal the registered population of busy bits, updated +1/-1/0 per edge with no over/underflow; a writeback to a non-busy register SHALL NOT decrement it.
REQ-015 i_clr during SWEEP SHALL be ignored (sweep continues).

Reset
REQ-016 i_rst_n=0 SHALL asynchronously force state=SWEEP, idx=0, all busy bits 0, o_pend_cnt=0, o_ready=0; array contents are not reset directly.
REQ-017 After deassertion, the sweep SHALL run; o_ready SHALL rise NREGS edges later.
REQ-018 Reset asserted mid-sweep or mid-traffic SHALL restart the sweep from idx=0.

Structure
REQ-019 Package rf_pkg SHALL hold the state encoding (SWEEP, READY) and the AW derivation function.
REQ-020 Busy bits, set/clear priority and o_pend_cnt SHALL live in sub-module rf_scoreboard; the array, sweep FSM and read muxes stay in rf_sb.

Verification
REQ-021 Reset release, NREGS=32: o_ready low 32 edges then high; all 32 registers read 0 on both ports.
REQ-022 Write x5=0xDEADBEEF, next cycle read port0=x5, port1=x0 -> 0xDEADBEEF and 0; write x0=1 -> x0 still 0.
REQ-023 BYPASS_EN=1, same-cycle write x7=0x1234 and read x7 -> 0x1234, o_rbusy=0; BYPASS_EN=0 -> old value until next edge.
REQ-024 Issue x3, x4, x3 writeback, then issue+writeback x4 same cycle -> o_pend_cnt 1,2,1,1; busy[4] stays 1.
REQ-025 After writes, pulse i_clr -> o_ready low 32 cycles, busy cleared, all reads 0 afterwards.
REQ-026 Assert i_rst_n=0 at sweep idx=10 -> o_ready stays low; sweep restarts at 0 and completes 32 edges after release.
